ysyx_22040759_dmem_responder: RTL
=================================

// Module: ysyx_22040759_dmem_responder
// PURPOSE
//   Data-memory responder, the slave end of the MEM-stage load/store interface.
//   Accepts one request at a time over a valid/ready handshake and waits a configurable latency.
//   Performs a sized, aligned access to an internal 64-bit-wide array.
//   Returns the load data (sign- or zero-extended) or a store acknowledge over a valid/ready response channel.
//   Replaces the zero-latency RAM so the MEM stage can be stalled through ms_ready_go.
// PARAMETERS
//   DEPTH_LOG2  12  log2 of the number of 64-bit words in the array
//   LATENCY     2   cycles from request accept to response valid; legal range 1..15
// PORTS
//   clk         in   1   clock
//   rst_n       in   1   asynchronous, active-low reset
//   req_valid   in   1   request present
//   req_ready   out  1   responder can accept a request
//   req_wen     in   1   store request
//   req_ren     in   1   load request
//   req_func3   in   3   RV64 size/sign code (000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu)
//   req_addr    in   64  byte address
//   req_wdata   in   64  store data, LSB-aligned
//   resp_valid  out  1   response present
//   resp_ready  in   1   requester accepts response
//   resp_rdata  out  64  extended load data; 0 for stores, errors and no-ops
//   resp_err    out  1   misaligned access or illegal func3
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     state=IDLE; req_ready=0; resp_valid=0; resp_rdata=0; resp_err=0.
//     req_ready rises on the first clk edge after rst_n is released.
//     Array contents are not reset.
//     Reset asserted mid-transaction aborts it; a pending store that has not reached its access cycle is NOT written.
//   FSM IDLE -> WAIT -> RESP -> IDLE
//     IDLE: req_ready=1. On req_valid&&req_ready, register wen/ren/func3/addr/wdata,
//       set cnt=LATENCY-1, set req_ready=0, go to WAIT.
//     WAIT: if cnt!=0, decrement cnt. If cnt==0 (access cycle), perform the access, register resp_rdata/resp_err,
//       set resp_valid=1 and go to RESP.
//     RESP: hold resp_valid, resp_rdata and resp_err stable until resp_valid&&resp_ready.
//       On that cycle, clear resp_valid, set req_ready=1 and go to IDLE.
//     No back-to-back overlap: a new request is accepted no earlier than the cycle after the response handshake.
//   Latency: request handshake at edge N gives resp_valid=1 after edge N+LATENCY.
//   Access rules
//     Word index = addr[DEPTH_LOG2+2:3]; higher address bits are ignored, so addresses wrap modulo the array size.
//     Alignment: h needs addr[0]==0; w needs addr[1:0]==0; d needs addr[2:0]==0.
//     Illegal func3: 111 for either direction; 1xx for stores.
//     A misaligned or illegal access sets resp_err=1, returns resp_rdata=0 and performs no write.
//     Store: byte mask by size, shifted by addr[2:0]; wdata shifted left by 8*addr[2:0]; only masked bytes change.
//     Load: word shifted right by 8*addr[2:0], truncated to the size, then sign-extended (b/h/w) or zero-extended (bu/hu/wu/d).
//     wen&&ren both 1: treated as illegal (resp_err=1, no write).
//     wen=ren=0: no-op that still completes the handshake (err=0, rdata=0).
//   Simultaneous events: resp_ready arriving in IDLE/WAIT is ignored. req_valid is not sampled outside IDLE.
// STRUCTURE
//   ysyx_22040759_define.v gains:
//     func3 codes (`FUNC3_B .. `FUNC3_WU);
//     FSM encodings (`DMR_IDLE, `DMR_WAIT, `DMR_RESP, 2 bits).
//   Sub-module ysyx_22040759_dmem_lane (combinational): func3 + addr[2:0] + wdata + old word
//     -> byte mask, merged write word, extracted and extended load data, and the err flag.
//   The array is a reg [63:0] mem[0:2**DEPTH_LOG2-1] in this module, written only in the access cycle.
// TESTING
//   1. sd addr 0x10 data 0x1122334455667788, then ld 0x10
//      -> err=0, rdata 0x1122334455667788; resp_valid 2 cycles after each accept (LATENCY=2).
//   2. After test 1: lb 0x17 -> 0x0000000000000011.
//      Then sb 0x17 data 0xFF, followed by lb 0x17 -> 0xFFFFFFFFFFFFFFFF and lbu 0x17 -> 0x00000000000000FF.
//   3. lw 0x12 -> err=1, rdata 0.
//      sd 0x14 data 0xDEAD -> err=1, and a following ld 0x10 shows the word unchanged.
//   4. Hold resp_ready=0 for 5 cycles in RESP -> resp_valid/rdata stable and req_ready=0 throughout.
//      Releasing resp_ready -> req_ready=1 the next cycle.
//   5. Drop rst_n in WAIT during sd 0x20 data 0x5 -> outputs return to reset values immediately.
//      After release, ld 0x20 returns the prior contents (store aborted).
//   6. sd to 0x8 + (2**DEPTH_LOG2)*8 data 0xAB -> ld 0x8 returns 0xAB (wrap-around).

Source files
------------

// File: rtl/ysyx_22040759_dmem_responder_pkg.sv
// Shared types for the data-memory responder: func3 codes, FSM states, registered request.
// Pure declarations; no timing or flow-control behaviour of its own.
package ysyx_22040759_dmem_responder_pkg;

    localparam logic [2:0] FUNC3_B  = 3'b000;
    localparam logic [2:0] FUNC3_H  = 3'b001;
    localparam logic [2:0] FUNC3_W  = 3'b010;
    localparam logic [2:0] FUNC3_D  = 3'b011;
    localparam logic [2:0] FUNC3_BU = 3'b100;
    localparam logic [2:0] FUNC3_HU = 3'b101;
    localparam logic [2:0] FUNC3_WU = 3'b110;

    typedef enum logic [1:0] {
        DMR_IDLE = 2'd0,
        DMR_WAIT = 2'd1,
        DMR_RESP = 2'd2
    } dmr_state_t;

    typedef struct packed {
        logic        wen;
        logic        ren;
        logic [2:0]  func3;
        logic [63:0] wdata;
    } dmr_req_t;

    // Byte-enable pattern for an access size of 1/2/4/8 bytes, unshifted.
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ysyx_22040759_dmem_responder_lane.sv
// Byte-lane logic: alignment/legality check, store merge and load extract/extend.
// Purely combinational, zero latency, no flow control.
module ysyx_22040759_dmem_lane
    import ysyx_22040759_dmem_responder_pkg::*;
(
    input  logic        i_wen,
    input  logic        i_ren,
    input  logic [2:0]  i_func3,
    input  logic [2:0]  i_offs,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_old_word,
    output logic [7:0]  o_byte_mask,
    output logic [63:0] o_merged_word,
    output logic [63:0] o_load_data,
    output logic        o_write_en,
    output logic        o_err
);

    logic        w_illegal;
    logic        w_misalign;
    logic [5:0]  w_shift;
    logic [63:0] w_wdata_sh;
    logic [63:0] w_rd_sh;
    logic [63:0] w_ext;

    assign w_shift    = {i_offs, 3'b000};
    assign w_illegal  = (i_func3 == 3'b111) || (i_wen && i_func3[2]) || (i_wen && i_ren);

    always_comb begin
        w_misalign = 1'b0;
        case (i_func3[1:0])
            2'b01:   w_misalign = i_offs[0];
            2'b10:   w_misalign = |i_offs[1:0];
            2'b11:   w_misalign = |i_offs;
            default: w_misalign = 1'b0;
        endcase
    end

    // A request with neither wen nor ren is a plain no-op and never flags an error.
    assign o_err      = (i_wen || i_ren) && (w_illegal || w_misalign);
    assign o_write_en = i_wen && !i_ren && !o_err;

    assign o_byte_mask = o_write_en ? (size_mask(i_func3[1:0]) << i_offs) : 8'h00;
    assign w_wdata_sh  = i_wdata << w_shift;

    always_comb begin
        o_merged_word = i_old_word;
        for (int b = 0; b < 8; b++) begin
            if (o_byte_mask[b]) begin
                o_merged_word[8*b +: 8] = w_wdata_sh[8*b +: 8];
            end
        end
    end

    assign w_rd_sh = i_old_word >> w_shift;

    always_comb begin
        w_ext = 64'd0;
        case (i_func3)
            FUNC3_B:  w_ext = {{56{w_rd_sh[7]}},  w_rd_sh[7:0]};
            FUNC3_H:  w_ext = {{48{w_rd_sh[15]}}, w_rd_sh[15:0]};
            FUNC3_W:  w_ext = {{32{w_rd_sh[31]}}, w_rd_sh[31:0]};
            FUNC3_D:  w_ext = w_rd_sh;
            FUNC3_BU: w_ext = {56'd0, w_rd_sh[7:0]};
            FUNC3_HU: w_ext = {48'd0, w_rd_sh[15:0]};
            FUNC3_WU: w_ext = {32'd0, w_rd_sh[31:0]};
            default:  w_ext = 64'd0;
        endcase
    end

    assign o_load_data = (i_ren && !i_wen && !o_err) ? w_ext : 64'd0;

endmodule

// File: rtl/ysyx_22040759_dmem_responder.sv
// Data-memory responder: one request at a time, response LATENCY cycles after accept.
// Response is held until resp_ready; no new request is accepted until the cycle after that.
module ysyx_22040759_dmem_responder
    import ysyx_22040759_dmem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic        req_ren,
    input  logic [2:0]  req_func3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int         AW       = DEPTH_LOG2 + 3;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [63:0] r_mem [0:(2**DEPTH_LOG2)-1];

    dmr_state_t        r_state, w_state_nxt;
    dmr_req_t          r_req, w_req_nxt;
    logic [AW-1:0]     r_addr, w_addr_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic              r_req_ready, w_req_ready_nxt;
    logic              r_resp_valid, w_resp_valid_nxt;
    logic [63:0]       r_resp_rdata, w_resp_rdata_nxt;
    logic              r_resp_err, w_resp_err_nxt;

    logic [DEPTH_LOG2-1:0] w_idx;
    logic [63:0]           w_old_word;
    logic [7:0]            w_byte_mask;
    logic [63:0]           w_merged_word;
    logic [63:0]           w_load_data;
    logic                  w_lane_we;
    logic                  w_lane_err;
    logic                  w_access;
    logic                  w_unused_addr_hi;

    // Address bits above the array index are deliberately dropped: accesses wrap.
    assign w_unused_addr_hi = ^req_addr[63:AW];

    assign w_idx      = r_addr[AW-1:3];
    assign w_old_word = r_mem[w_idx];
    assign w_access   = (r_state == DMR_WAIT) && (r_cnt == 4'd0);

    ysyx_22040759_dmem_lane u_lane (
        .i_wen         (r_req.wen),
        .i_ren         (r_req.ren),
        .i_func3       (r_req.func3),
        .i_offs        (r_addr[2:0]),
        .i_wdata       (r_req.wdata),
        .i_old_word    (w_old_word),
        .o_byte_mask   (w_byte_mask),
        .o_merged_word (w_merged_word),
        .o_load_data   (w_load_data),
        .o_write_en    (w_lane_we),
        .o_err         (w_lane_err)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_req_nxt        = r_req;
        w_addr_nxt       = r_addr;
        w_cnt_nxt        = r_cnt;
        w_req_ready_nxt  = r_req_ready;
        w_resp_valid_nxt = r_resp_valid;
        w_resp_rdata_nxt = r_resp_rdata;
        w_resp_err_nxt   = r_resp_err;
        case (r_state)
            DMR_IDLE: begin
                w_req_ready_nxt = 1'b1;
                if (req_valid && r_req_ready) begin
                    w_req_nxt       = '{wen: req_wen, ren: req_ren, func3: req_func3, wdata: req_wdata};
                    w_addr_nxt      = req_addr[AW-1:0];
                    w_cnt_nxt       = CNT_INIT;
                    w_req_ready_nxt = 1'b0;
                    w_state_nxt     = DMR_WAIT;
                end
            end
            DMR_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_resp_rdata_nxt = w_load_data;
                    w_resp_err_nxt   = w_lane_err;
                    w_resp_valid_nxt = 1'b1;
                    w_state_nxt      = DMR_RESP;
                end
            end
            DMR_RESP: begin
                if (resp_ready) begin
                    w_resp_valid_nxt = 1'b0;
                    w_req_ready_nxt  = 1'b1;
                    w_state_nxt      = DMR_IDLE;
                end
            end
            default: begin
                w_state_nxt = DMR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= DMR_IDLE;
            r_req        <= '0;
            r_addr       <= '0;
            r_cnt        <= 4'd0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 64'd0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_req        <= w_req_nxt;
            r_addr       <= w_addr_nxt;
            r_cnt        <= w_cnt_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_resp_err   <= w_resp_err_nxt;
        end
    end

    // Reset forces IDLE asynchronously, so an aborted store never reaches this write.
    always_ff @(posedge clk) begin
        if (w_access && w_lane_we) begin
            r_mem[w_idx] <= w_merged_word;
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
